// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file and its commit trace.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_regfile_pkg;

    localparam int          RF_DW     = 32;
    localparam int          RF_AW     = 5;
    localparam logic [4:0]  RF_ZERO   = 5'd0;
    localparam logic [31:0] PC_BUBBLE = 32'h0;

endpackage

// File: rtl/wb_regfile_commit_trace.sv
// Registered commit trace (PC, write enable/addr/data) and retired-instruction counter.
// Latency: 1 cycle from WB inputs to debug_* / commit_cnt.
// Backpressure: none; samples the WB stage every cycle, bubbles (pc == 0) do not count.
module wb_commit_trace
    import wb_regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [31:0]   pc,
    output logic [31:0]   debug_wb_pc,
    output logic          debug_wb_rf_wen,
    output logic [AW-1:0] debug_wb_rf_wnum,
    output logic [DW-1:0] debug_wb_rf_wdata,
    output logic [31:0]   commit_cnt
);

    logic [31:0] cnt_q;

    assign commit_cnt = cnt_q;

    // Trace registers mirror the WB inputs one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_wb_pc       <= 32'h0;
            debug_wb_rf_wen   <= 1'b0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_pc       <= pc;
            debug_wb_rf_wen   <= wen;
            debug_wb_rf_wnum  <= waddr;
            debug_wb_rf_wdata <= wdata;
        end
    end

    // Count every non-bubble instruction; wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'h0;
        end else if (pc != PC_BUBBLE) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file: WB write port, two combinational ID read ports, commit trace.
// Latency: write visible next cycle (same cycle with WB_REGFILE_BYPASS_EN); reads 0 cycles.
// Backpressure: none; every WB write is accepted. Optional macro: WB_REGFILE_BYPASS_EN.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic [31:0]   wb_pc,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [31:0]   debug_wb_pc,
    output logic          debug_wb_rf_wen,
    output logic [AW-1:0] debug_wb_rf_wnum,
    output logic [DW-1:0] debug_wb_rf_wdata,
    output logic [31:0]   commit_cnt
);

    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO);

    logic [DW-1:0] rf [NREG];
    logic          wr_eff;

    // Register 0 is hard-wired, so a write aimed at it is discarded here.
    assign wr_eff = wb_we && (wb_waddr != ZERO_ADDR);

    // Array update; entry 0 is only ever reset, never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_eff) begin
            rf[wb_waddr] <= wb_wdata;
        end
    end

    // Read port 1: zero when disabled or addressing r0, optional WB bypass.
    always_comb begin
        rdata1 = '0;
        if (re1 && (raddr1 != ZERO_ADDR)) begin
            rdata1 = rf[raddr1];
`ifdef WB_REGFILE_BYPASS_EN
            if (wr_eff && (raddr1 == wb_waddr)) begin
                rdata1 = wb_wdata;
            end
`endif
        end
    end

    // Read port 2: same rules as port 1, fully independent.
    always_comb begin
        rdata2 = '0;
        if (re2 && (raddr2 != ZERO_ADDR)) begin
            rdata2 = rf[raddr2];
`ifdef WB_REGFILE_BYPASS_EN
            if (wr_eff && (raddr2 == wb_waddr)) begin
                rdata2 = wb_wdata;
            end
`endif
        end
    end

    wb_commit_trace #(
        .DW (DW),
        .AW (AW)
    ) u_trace (
        .clk               (clk),
        .rst_n             (rst_n),
        .wen               (wr_eff),
        .waddr             (wb_waddr),
        .wdata             (wb_wdata),
        .pc                (wb_pc),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .commit_cnt        (commit_cnt)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based reference model.
// Latency: inputs driven 1 time unit after each rising edge, reads sampled mid-cycle.
// Backpressure: n/a.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic [31:0]   wb_pc;
    logic          re1, re2;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2;
    logic [31:0]   debug_wb_pc;
    logic          debug_wb_rf_wen;
    logic [AW-1:0] debug_wb_rf_wnum;
    logic [DW-1:0] debug_wb_rf_wdata;
    logic [31:0]   commit_cnt;

    int tests_run;
    int tests_failed;

    // Reference state: what the architecture says the registers hold.
    logic [DW-1:0] m_rf [32];
    logic [31:0]   m_cnt;
    logic [31:0]   m_pc;
    logic          m_wen;
    logic [AW-1:0] m_wnum;
    logic [DW-1:0] m_wdata;

    wb_regfile #(.DW(DW), .AW(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wb_we             (wb_we),
        .wb_waddr          (wb_waddr),
        .wb_wdata          (wb_wdata),
        .wb_pc             (wb_pc),
        .re1               (re1),
        .raddr1            (raddr1),
        .re2               (re2),
        .raddr2            (raddr2),
        .rdata1            (rdata1),
        .rdata2            (rdata2),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .commit_cnt        (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_cnt = 0; m_pc = 0; m_wen = 0; m_wnum = 0; m_wdata = 0;
    endtask

    // Expected read value from the architectural rules.
    function automatic logic [DW-1:0] exp_rd(input logic re, input logic [AW-1:0] ra);
        if (!re || ra == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_we && wb_waddr != 0 && ra == wb_waddr) return wb_wdata;
`endif
        return m_rf[ra];
    endfunction

    task automatic drv(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [31:0] pc, input logic r1, input logic [AW-1:0] a1,
                       input logic r2, input logic [AW-1:0] a2);
        wb_we = we; wb_waddr = wa; wb_wdata = wd; wb_pc = pc;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Advance one rising edge, apply the same edge to the model, settle.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            m_pc = wb_pc; m_wen = wb_we && wb_waddr != 0; m_wnum = wb_waddr; m_wdata = wb_wdata;
            if (wb_we && wb_waddr != 0) m_rf[wb_waddr] = wb_wdata;
            if (wb_pc != 0) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            drv(0, 0, 0, 0, 1, AW'(i), 1, AW'(i));
            #1;
            tests_run++;
            if (rdata1 !== 0 || rdata2 !== 0) begin
                tests_failed++;
                $display("FAIL reset_read r%0d: got %h/%h want 0", i, rdata1, rdata2);
            end
        end
        tests_run++;
        if (commit_cnt !== 0 || debug_wb_pc !== 0 || debug_wb_rf_wen !== 0 ||
            debug_wb_rf_wnum !== 0 || debug_wb_rf_wdata !== 0) begin
            tests_failed++;
            $display("FAIL reset_trace: cnt=%h pc=%h wen=%b wnum=%0d wdata=%h want all 0",
                     commit_cnt, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
    endtask

    task automatic test_basic();
        drv(1, 5, 32'hDEADBEEF, 32'hBFC00000, 0, 0, 0, 0);
        step();
        tests_run++;
        if (debug_wb_pc !== 32'hBFC00000 || debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5 ||
            debug_wb_rf_wdata !== 32'hDEADBEEF || commit_cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL basic_trace: pc=%h wen=%b wnum=%0d wdata=%h cnt=%0d want bfc00000/1/5/deadbeef/1",
                     debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, commit_cnt);
        end
        drv(0, 0, 0, 0, 1, 5, 1, 5);
        #2;
        tests_run++;
        if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL basic_read: got %h/%h want deadbeef", rdata1, rdata2);
        end
        step();
    endtask

    task automatic test_zero_reg();
        drv(1, 0, 32'h12345678, 32'hBFC00004, 0, 0, 0, 0);
        step();
        tests_run++;
        if (debug_wb_rf_wen !== 1'b0 || commit_cnt !== m_cnt) begin
            tests_failed++;
            $display("FAIL zero_wen: wen=%b cnt=%0d want 0/%0d", debug_wb_rf_wen, commit_cnt, m_cnt);
        end
        drv(0, 0, 0, 0, 1, 0, 0, 5);
        #2;
        tests_run++;
        if (rdata1 !== 0 || rdata2 !== 0) begin
            tests_failed++;
            $display("FAIL zero_read: r0=%h re2_off=%h want 0/0", rdata1, rdata2);
        end
        step();
    endtask

    task automatic test_hazard();
        drv(1, 7, 32'h11, 32'h100, 0, 0, 0, 0);
        step();
        drv(1, 7, 32'h22, 32'h104, 1, 7, 1, 7);
        #2;
        tests_run++;
`ifdef WB_REGFILE_BYPASS_EN
        if (rdata1 !== 32'h22 || rdata2 !== 32'h22) begin
            tests_failed++;
            $display("FAIL hazard_same: got %h/%h want 22/22", rdata1, rdata2);
        end
`else
        if (rdata1 !== 32'h11 || rdata2 !== 32'h11) begin
            tests_failed++;
            $display("FAIL hazard_same: got %h/%h want 11/11", rdata1, rdata2);
        end
`endif
        step();
        drv(0, 0, 0, 0, 1, 7, 1, 7);
        #2;
        tests_run++;
        if (rdata1 !== 32'h22 || rdata2 !== 32'h22) begin
            tests_failed++;
            $display("FAIL hazard_next: got %h/%h want 22/22", rdata1, rdata2);
        end
        step();
    endtask

    task automatic test_bubble_wrap();
        for (int i = 0; i < 4; i++) begin
            drv(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 0, 0, 0, 0, 0);
            step();
            tests_run++;
            if (commit_cnt !== m_cnt || debug_wb_pc !== 0) begin
                tests_failed++;
                $display("FAIL bubble_cnt: cnt=%0d pc=%h want %0d/0", commit_cnt, debug_wb_pc, m_cnt);
            end
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        force dut.u_trace.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.u_trace.cnt_q;
        m_cnt = 32'hFFFFFFFF;
        drv(0, 0, 0, 32'h80000000, 0, 0, 0, 0);
        step();
        tests_run++;
        if (commit_cnt !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_cnt: got %h want 00000000", commit_cnt);
        end
        m_cnt = 0;
        drv(0, 0, 0, 32'h80000004, 0, 0, 0, 0);
        step();
        tests_run++;
        if (commit_cnt !== 32'h1) begin
            tests_failed++;
            $display("FAIL wrap_after: got %h want 00000001", commit_cnt);
        end
    endtask

    // Random traffic with addresses biased into a small window to provoke collisions.
    task automatic test_random();
        logic [AW-1:0] a1, a2, wa;
        for (int n = 0; n < 400; n++) begin
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, 7));
            drv(1'($urandom_range(0, 1)), wa, $urandom,
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                1'($urandom_range(0, 3) != 0), a1, 1'($urandom_range(0, 3) != 0), a2);
            #2;
            tests_run++;
            if (rdata1 !== exp_rd(re1, raddr1) || rdata2 !== exp_rd(re2, raddr2)) begin
                tests_failed++;
                $display("FAIL rand_read #%0d: got %h/%h want %h/%h", n, rdata1, rdata2,
                         exp_rd(re1, raddr1), exp_rd(re2, raddr2));
            end
            step();
            tests_run++;
            if (debug_wb_pc !== m_pc || debug_wb_rf_wen !== m_wen || debug_wb_rf_wnum !== m_wnum ||
                debug_wb_rf_wdata !== m_wdata || commit_cnt !== m_cnt) begin
                tests_failed++;
                $display("FAIL rand_trace #%0d: got %h/%b/%0d/%h/%0d want %h/%b/%0d/%h/%0d", n,
                         debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, commit_cnt,
                         m_pc, m_wen, m_wnum, m_wdata, m_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        drv(1, 9, 32'hA5A5A5A5, 32'h200, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 1, 9, 1, 9);
        #1;
        tests_run++;
        if (rdata1 !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL mid_pre: r9=%h want a5a5a5a5", rdata1);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (rdata1 !== 0 || rdata2 !== 0 || commit_cnt !== 0 || debug_wb_pc !== 0 ||
            debug_wb_rf_wen !== 0 || debug_wb_rf_wnum !== 0 || debug_wb_rf_wdata !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset: r9=%h/%h cnt=%h pc=%h wen=%b wnum=%0d wdata=%h want all 0",
                     rdata1, rdata2, commit_cnt, debug_wb_pc, debug_wb_rf_wen,
                     debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        // A write presented while reset is held is lost.
        drv(1, 9, 32'h5A5A5A5A, 32'h204, 1, 9, 0, 0);
        step();
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 1, 9, 0, 0);
        #1;
        tests_run++;
        if (rdata1 !== 0 || commit_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_wins: r9=%h cnt=%0d want 0/0", rdata1, commit_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_basic();
        test_zero_reg();
        test_hazard();
        test_bubble_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file at the write-back end of the five-stage pipeline. It consumes the WB-stage write port and commit PC, where a bubble is signalled by a zero PC, and serves the two ID-stage read ports. It also produces a registered commit trace and a retired-instruction counter for debug and verification. Writes commit on the clock edge; reads are combinational, with optional same-cycle write-to-read bypass.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 5: register address width; 2^AW registers.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wb_we`  in  1  WB write enable.
- `wb_waddr`  in  AW  WB destination register.
- `wb_wdata`  in  DW  WB write data.
- `wb_pc`  in  32  PC of the instruction in WB; 0 means bubble.
- `re1` / `re2`  in  1  read enables, ports 1 and 2.
- `raddr1` / `raddr2`  in  AW  read addresses.
- `rdata1` / `rdata2`  out  DW  read data, combinational.
- `debug_wb_pc`  out  32  registered commit PC.
- `debug_wb_rf_wen`  out  1  registered effective write enable.
- `debug_wb_rf_wnum`  out  AW  registered write address.
- `debug_wb_rf_wdata`  out  DW  registered write data.
- `commit_cnt`  out  32  retired-instruction count.

## Operation
- Effective write: `wb_we && wb_waddr != 0`.
  - On `clk` rise, `rf[wb_waddr] <= wb_wdata`.
  - Register 0 is never written and always reads 0.
- Read port n:
  - Output is 0 if `re_n == 0` or `raddr_n == 0`.
  - Otherwise the output is `rf[raddr_n]`, subject to the bypass rule in Configuration.
- The two read ports are independent. Both may address the same register, and both may match the write address in the same cycle.
- Commit trace, updated on every `clk` rise:
  - `debug_wb_pc <= wb_pc`
  - `debug_wb_rf_wen <=` effective write
  - `debug_wb_rf_wnum <= wb_waddr`
  - `debug_wb_rf_wdata <= wb_wdata`
- Commit counter: `commit_cnt` increments by 1 on each `clk` rise where `wb_pc != 0`.
  - Modulo 2^32: 0xFFFFFFFF goes to 0 with no sticky flag.
  - Bubbles (`wb_pc == 0`) leave it unchanged.
- A bubble with `wb_we == 1` still performs the write. Validity of the write is the job of the upstream pipeline; this block does not gate writes on PC.
- No state machine; the state is the register array, the trace registers and the counter.

## Timing
- Reset (`rst_n` low, asynchronous): all `rf` entries, every `debug_*` output and `commit_cnt` go to 0 immediately.
  - `rdata1/2` read 0 while reset is held, since all entries are 0.
  - Reset release is synchronised upstream; the first write is accepted on the first rising edge with `rst_n` high.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Write latency: data is visible to a non-bypassed read starting the cycle after the write edge.
- Read latency: 0 cycles; combinational from `raddr`, `re` and the array (plus the WB inputs when bypass is enabled).
- Trace latency: exactly 1 cycle after the WB inputs are presented.
- Counter latency: `commit_cnt` reflects a commit 1 cycle after `wb_pc != 0` is presented.

## Configuration
- Macro `WB_REGFILE_BYPASS_EN`.
- When defined: if the effective write is active and `raddr_n == wb_waddr` and `re_n == 1`, then `rdata_n = wb_wdata` in the same cycle. This removes the WB→ID hazard.
- When undefined: the read returns the pre-write array value in that cycle. The hazard is then handled by stall or forwarding logic upstream.

## Structure
- Shared package holds:
  - `RF_DW = 32`, `RF_AW = 5`, `RF_ZERO = 5'd0`.
  - `PC_BUBBLE = 32'h0`.
- Sub-module `wb_commit_trace` owns the four `debug_*` registers and `commit_cnt`.
- The top level holds the array, the read muxes and the bypass.

## Test plan
- Reset then read: assert `rst_n = 0` for 3 cycles, release, read r1..r31 → all 0; `commit_cnt = 0`, all `debug_*` = 0.
- Basic write/read: write r5 = 0xDEADBEEF with `wb_pc = 0xBFC00000`; next cycle `raddr1 = 5` → 0xDEADBEEF.
  - Same edge: `debug_wb_pc = 0xBFC00000`, `debug_wb_rf_wen = 1`, `debug_wb_rf_wnum = 5`, `commit_cnt = 1`.
- Zero register: write r0 = 0x12345678 → `raddr1 = 0` reads 0 and `debug_wb_rf_wen = 0`. Read any register with `re2 = 0` → 0.
- Same-cycle hazard: r7 holds 0x11; in one cycle write r7 = 0x22 while reading r7 on both ports.
  - With `WB_REGFILE_BYPASS_EN`: both ports read 0x22 in that cycle.
  - Without it: both read 0x11, then 0x22 on the next cycle.
- Bubble and wrap:
  - Present `wb_pc = 0` for 4 cycles → `commit_cnt` unchanged.
  - Force the counter to 0xFFFFFFFF and commit once with `wb_pc = 0x80000000` → `commit_cnt = 0`.
- Reset mid-operation: write r9 = 0xA5A5A5A5, then drop `rst_n` between edges → r9 reads 0 without any clock edge; `commit_cnt = 0` and all `debug_*` = 0 asynchronously.
